dmem_arbiter: RTL and testbench

Sequencer and arbiter placed in front of the data-memory RAM (`dmem_ram`). It grants single-word read/write accesses to NREQ requesters in round-robin order and drives the RAM's `we`/`address`/`wd` ports from registers. On a rising edge of the `switchStart` switch it blocks new accesses and sweeps the whole RAM, streaming every word out for image dump or capture.

---
 rtl/dmem_ctrl_pkg.sv | 19 +
 rtl/dmem_rr_pick.sv | 33 +++
 rtl/dmem_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared types and default geometry for the data-memory sequencer/arbiter.
package dmem_ctrl_pkg;

    localparam int DEF_S    = 32;
    localparam int DEF_SIZE = 30;
    localparam int DEF_NREQ = 2;

    typedef enum logic [1:0] {
        ARB  = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a requester index; a single requester still needs one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Combinational round-robin picker: the search starts one past the last winner.
module dmem_rr_pick
    import dmem_ctrl_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int IW   = idx_width(DEF_NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [NREQ-1:0] winner_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    logic [IW-1:0] cand;

    // NOTE: every output gets a default before the loop so no path leaves a latch.
    always_comb begin
        winner_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IW'((int'(last_i) + k) % NREQ);
            if (!any_o && req_i[cand]) begin
                winner_o[cand] = 1'b1;
                idx_o          = cand;
                any_o          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin access arbiter in front of dmem_ram, with a switch-triggered
// full-memory dump that streams every word out in address order.
module dmem_arbiter
    import dmem_ctrl_pkg::*;
#(
    parameter int S    = DEF_S,
    parameter int SIZE = DEF_SIZE,
    parameter int NREQ = DEF_NREQ,
    parameter int AW   = $clog2(SIZE)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   switchStart,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ-1:0][S-1:0] req_addr,
    input  logic [NREQ-1:0][S-1:0] req_wd,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        rvalid,
    output logic [S-1:0]           rdata,
    output logic                   addr_err,
    output logic                   mem_we,
    output logic [S-1:0]           mem_address,
    output logic [S-1:0]           mem_wd,
    input  logic [S-1:0]           mem_rd,
    output logic                   dump_valid,
    output logic [AW-1:0]          dump_addr,
    output logic [S-1:0]           dump_data,
    output logic                   busy,
    output logic                   dump_done
);

    localparam int            IW     = idx_width(NREQ);
    localparam logic [S-1:0]  SIZE_W = S'(SIZE);
    localparam logic [AW-1:0] LAST_A = AW'(SIZE - 1);

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   last_q, last_d;
    logic            sync1_q, sync2_q, sw_prev_q;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            acc_we_q, acc_we_d;
    logic            addr_err_q, addr_err_d;
    logic            mem_we_q, mem_we_d;
    logic [S-1:0]    mem_address_q, mem_address_d;
    logic [S-1:0]    mem_wd_q, mem_wd_d;
    logic [NREQ-1:0] rvalid_q, rvalid_d;
    logic [S-1:0]    rdata_q, rdata_d;
    logic            dump_valid_q, dump_valid_d;
    logic [AW-1:0]   dump_addr_q, dump_addr_d;
    logic [S-1:0]    dump_data_q, dump_data_d;
    logic            dump_done_q, dump_done_d;

    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            sw_edge;
    logic            grant_ok;
    logic            oor;

    // A requester holding its gnt this cycle is masked so it cannot win twice in a row.
    dmem_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req_i    (req & ~gnt_q),
        .last_i   (last_q),
        .winner_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    assign sw_edge = sync2_q & ~sw_prev_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ARB;
            cnt_q         <= '0;
            last_q        <= IW'(NREQ - 1);
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            sw_prev_q     <= 1'b0;
            gnt_q         <= '0;
            acc_we_q      <= 1'b0;
            addr_err_q    <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_address_q <= '0;
            mem_wd_q      <= '0;
            rvalid_q      <= '0;
            rdata_q       <= '0;
            dump_valid_q  <= 1'b0;
            dump_addr_q   <= '0;
            dump_data_q   <= '0;
            dump_done_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            last_q        <= last_d;
            sync1_q       <= switchStart;
            sync2_q       <= sync1_q;
            sw_prev_q     <= sync2_q;
            gnt_q         <= gnt_d;
            acc_we_q      <= acc_we_d;
            addr_err_q    <= addr_err_d;
            mem_we_q      <= mem_we_d;
            mem_address_q <= mem_address_d;
            mem_wd_q      <= mem_wd_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            dump_valid_q  <= dump_valid_d;
            dump_addr_q   <= dump_addr_d;
            dump_data_q   <= dump_data_d;
            dump_done_q   <= dump_done_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        last_d        = last_q;
        gnt_d         = '0;
        acc_we_d      = acc_we_q;
        addr_err_d    = 1'b0;
        mem_we_d      = 1'b0;
        mem_address_d = mem_address_q;
        mem_wd_d      = mem_wd_q;
        rvalid_d      = '0;
        rdata_d       = '0;
        dump_valid_d  = 1'b0;
        dump_addr_d   = '0;
        dump_data_d   = '0;
        dump_done_d   = (state_q == DONE);
        grant_ok      = 1'b0;
        oor           = 1'b0;

        // A read granted last cycle completes in any state, including dump entry.
        if ((|gnt_q) && !acc_we_q) begin
            rvalid_d = gnt_q;
            rdata_d  = addr_err_q ? '0 : mem_rd;
        end

        case (state_q)
            ARB: begin
                if (sw_edge) begin
                    state_d       = DUMP;
                    cnt_d         = '0;
                    mem_address_d = '0;
                end else begin
                    grant_ok = pick_any;
                end
            end
            DUMP: begin
                dump_valid_d = 1'b1;
                dump_addr_d  = cnt_q;
                dump_data_d  = mem_rd;
                if (cnt_q == LAST_A) begin
                    state_d = DONE;
                end else begin
                    cnt_d         = cnt_q + AW'(1);
                    mem_address_d = S'(cnt_q + AW'(1));
                end
            end
            DONE: begin
                state_d  = ARB;
                cnt_d    = '0;
                grant_ok = pick_any;
            end
            default: state_d = ARB;
        endcase

        if (grant_ok) begin
            oor           = (req_addr[pick_idx] >= SIZE_W);
            gnt_d         = pick_onehot;
            last_d        = pick_idx;
            acc_we_d      = req_we[pick_idx];
            addr_err_d    = oor;
            mem_we_d      = req_we[pick_idx] & ~oor;
            mem_address_d = req_addr[pick_idx];
            mem_wd_d      = req_wd[pick_idx];
        end
    end

    assign gnt         = gnt_q;
    assign rvalid      = rvalid_q;
    assign rdata       = rdata_q;
    assign addr_err    = addr_err_q;
    assign mem_we      = mem_we_q;
    assign mem_address = mem_address_q;
    assign mem_wd      = mem_wd_q;
    assign dump_valid  = dump_valid_q;
    assign dump_addr   = dump_addr_q;
    assign dump_data   = dump_data_q;
    assign busy        = (state_q != ARB);
    assign dump_done   = dump_done_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural dmem_ram (negedge write, async read).
module tb_dmem_arbiter;

    localparam int S    = 32;
    localparam int SIZE = 30;
    localparam int NREQ = 2;
    localparam int AW   = 5;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   switchStart;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_we;
    logic [NREQ-1:0][S-1:0] req_addr;
    logic [NREQ-1:0][S-1:0] req_wd;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rvalid;
    logic [S-1:0]           rdata;
    logic                   addr_err;
    logic                   mem_we;
    logic [S-1:0]           mem_address;
    logic [S-1:0]           mem_wd;
    logic [S-1:0]           mem_rd;
    logic                   dump_valid;
    logic [AW-1:0]          dump_addr;
    logic [S-1:0]           dump_data;
    logic                   busy;
    logic                   dump_done;

    logic [S-1:0] ram [SIZE];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .S    (S),
        .SIZE (SIZE),
        .NREQ (NREQ),
        .AW   (AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .switchStart (switchStart),
        .req         (req),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_wd      (req_wd),
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .addr_err    (addr_err),
        .mem_we      (mem_we),
        .mem_address (mem_address),
        .mem_wd      (mem_wd),
        .mem_rd      (mem_rd),
        .dump_valid  (dump_valid),
        .dump_addr   (dump_addr),
        .dump_data   (dump_data),
        .busy        (busy),
        .dump_done   (dump_done)
    );

    // Out-of-range reads return a poison pattern so the arbiter must zero rdata itself.
    always @(negedge clk)
        if (mem_we && mem_address < S'(SIZE))
            ram[mem_address[AW-1:0]] <= mem_wd;

    assign mem_rd = (mem_address < S'(SIZE)) ? ram[mem_address[AW-1:0]] : 32'hBAD0_BAD0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_ctl"}, 64'({gnt, rvalid, addr_err, mem_we, dump_valid, dump_addr, busy, dump_done}), 64'd0);
        check({tag, "_rd_addr"}, {rdata, mem_address}, 64'd0);
        check({tag, "_wd_dump"}, {mem_wd, dump_data}, 64'd0);
    endtask

    task automatic do_write(input int i, input logic [S-1:0] a, input logic [S-1:0] d);
        req_we[i]   = 1'b1;
        req_addr[i] = a;
        req_wd[i]   = d;
        req[i]      = 1'b1;
        tick();
        check("wr_gnt", 64'(gnt), 64'(2'(1 << i)));
        req[i] = 1'b0;
        tick();
    endtask

    initial begin
        int  bad;
        int  seen;
        bit  done_seen;

        rst_n       = 1'b0;
        switchStart = 1'b0;
        req         = '0;
        req_we      = '0;
        req_addr    = '0;
        req_wd      = '0;
        tick();
        tick();
        check_quiet("reset");
        rst_n = 1'b1;
        tick();

        // Single write via req0, then read back via req1.
        req_we[0] = 1'b1; req_addr[0] = 32'd5; req_wd[0] = 32'hDEAD_BEEF; req[0] = 1'b1;
        tick();
        check("w5_gnt", 64'(gnt), 64'h1);
        check("w5_we", 64'(mem_we), 64'h1);
        check("w5_addr", 64'(mem_address), 64'd5);
        check("w5_wd", 64'(mem_wd), 64'hDEAD_BEEF);
        check("w5_err", 64'(addr_err), 64'h0);
        req[0] = 1'b0;
        tick();
        check("w5_rvalid", 64'(rvalid), 64'h0);
        check("w5_ram", 64'(ram[5]), 64'hDEAD_BEEF);
        do_write(0, 32'd6, 32'hCAFE_F00D);

        req_we[1] = 1'b0; req_addr[1] = 32'd5; req[1] = 1'b1;
        tick();
        check("r5_gnt", 64'(gnt), 64'h2);
        check("r5_we", 64'(mem_we), 64'h0);
        check("r5_addr", 64'(mem_address), 64'd5);
        req[1] = 1'b0;
        tick();
        check("r5_rvalid", 64'(rvalid), 64'h2);
        check("r5_rdata", 64'(rdata), 64'hDEAD_BEEF);
        tick();
        check("r5_rvalid_off", 64'(rvalid), 64'h0);

        // Contention: both read continuously; req0 wins first after req1's grant.
        req_we = 2'b00; req_addr[0] = 32'd6; req_addr[1] = 32'd5; req = 2'b11;
        tick();
        check("cont1_gnt", 64'(gnt), 64'h1);
        check("cont1_addr", 64'(mem_address), 64'd6);
        tick();
        check("cont2_gnt", 64'(gnt), 64'h2);
        check("cont2_rvalid", 64'(rvalid), 64'h1);
        check("cont2_rdata", 64'(rdata), 64'hCAFE_F00D);
        tick();
        check("cont3_gnt", 64'(gnt), 64'h1);
        check("cont3_rvalid", 64'(rvalid), 64'h2);
        check("cont3_rdata", 64'(rdata), 64'hDEAD_BEEF);
        tick();
        check("cont4_gnt", 64'(gnt), 64'h2);
        check("cont4_rdata", 64'(rdata), 64'hCAFE_F00D);
        req = 2'b00;
        tick();
        check("cont5_gnt", 64'(gnt), 64'h0);
        check("cont5_rvalid", 64'(rvalid), 64'h2);
        tick();
        check("cont6_rvalid", 64'(rvalid), 64'h0);

        // Preload address k with k+0x100.
        for (int k = 0; k < SIZE; k++) do_write(0, S'(k), S'(k + 32'h100));

        // Out-of-range write and read.
        req_we[0] = 1'b1; req_addr[0] = 32'd30; req_wd[0] = 32'h1234; req[0] = 1'b1;
        tick();
        check("oorw_gnt", 64'(gnt), 64'h1);
        check("oorw_err", 64'(addr_err), 64'h1);
        check("oorw_we", 64'(mem_we), 64'h0);
        req[0] = 1'b0;
        tick();
        check("oorw_err_off", 64'(addr_err), 64'h0);
        check("oorw_rvalid", 64'(rvalid), 64'h0);
        bad = 0;
        for (int k = 0; k < SIZE; k++) if (ram[k] !== S'(k + 32'h100)) bad++;
        check("oorw_ram_intact", 64'(bad), 64'd0);

        req_we[0] = 1'b0; req_addr[0] = 32'd40; req[0] = 1'b1;
        tick();
        check("oorr_err", 64'(addr_err), 64'h1);
        req[0] = 1'b0;
        tick();
        check("oorr_rvalid", 64'(rvalid), 64'h1);
        check("oorr_rdata", 64'(rdata), 64'h0);
        check("oorr_err_off", 64'(addr_err), 64'h0);

        // Dump with req0 pending and a second switch edge mid-dump.
        switchStart = 1'b1;
        tick();
        tick();
        check("dump_pre_busy", 64'(busy), 64'h0);
        tick();
        check("dump_busy", 64'(busy), 64'h1);
        check("dump_addr0", 64'(mem_address), 64'd0);
        check("dump_we", 64'(mem_we), 64'h0);
        check("dump_valid_lat", 64'(dump_valid), 64'h0);
        req_we[0] = 1'b0; req_addr[0] = 32'd3; req[0] = 1'b1;
        for (int k = 0; k < SIZE; k++) begin
            tick();
            check("dump_valid", 64'(dump_valid), 64'h1);
            check("dump_addr", 64'(dump_addr), 64'(k));
            check("dump_data", 64'(dump_data), 64'(k + 32'h100));
            check("dump_no_gnt", 64'({gnt, dump_done}), 64'h0);
            if (k == 1) switchStart = 1'b0;
            if (k == 6) switchStart = 1'b1;
        end
        check("done_busy", 64'(busy), 64'h1);
        tick();
        check("dump_done", 64'(dump_done), 64'h1);
        check("post_valid", 64'(dump_valid), 64'h0);
        check("post_gnt", 64'(gnt), 64'h1);
        check("post_addr", 64'(mem_address), 64'd3);
        check("post_busy", 64'(busy), 64'h0);
        req[0] = 1'b0;
        tick();
        check("post_done_off", 64'(dump_done), 64'h0);
        check("post_rvalid", 64'(rvalid), 64'h1);
        check("post_rdata", 64'(rdata), 64'h103);
        tick();
        check("no_restart", 64'(busy), 64'h0);

        // Reset in the middle of a dump, then restart.
        switchStart = 1'b0;
        repeat (3) tick();
        switchStart = 1'b1;
        repeat (3) tick();
        check("mid_busy", 64'(busy), 64'h1);
        repeat (10) tick();
        check("mid_valid", 64'(dump_valid), 64'h1);
        rst_n       = 1'b0;
        switchStart = 1'b0;
        tick();
        check_quiet("mid_rst");
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (dump_done || dump_valid || busy) seen++;
        end
        check("no_done_after_rst", 64'(seen), 64'd0);
        switchStart = 1'b1;
        repeat (3) tick();
        check("restart_busy", 64'(busy), 64'h1);
        check("restart_addr", 64'(mem_address), 64'd0);
        tick();
        check("restart_d0", 64'({dump_valid, dump_addr, dump_data}), {1'b1, 5'd0, 32'h100});
        tick();
        check("restart_d1", 64'({dump_valid, dump_addr, dump_data}), {1'b1, 5'd1, 32'h101});
        done_seen = 1'b0;
        for (int c = 0; c < 60 && !done_seen; c++) begin
            tick();
            if (dump_done) done_seen = 1'b1;
        end
        check("restart_done", 64'(done_seen), 64'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
